// File: rtl/pause_pkg.sv
// Shared types and defaults for the pause arbiter: FSM state encoding and counter sizing.
package pause_pkg;

  typedef enum logic [1:0] {
    PS_RUN         = 2'd0,
    PS_PEND_PAUSE  = 2'd1,
    PS_PAUSED      = 2'd2,
    PS_PEND_RESUME = 2'd3
  } pause_state_t;

  localparam int unsigned PAUSE_TIMEOUT_DEF  = 1000000;
  localparam int unsigned PAUSE_MIN_HOLD_DEF = 16;

  // Counter width for a count of n; never narrower than one bit.
  function automatic int unsigned pause_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/synch_2.sv
// Two-flop synchroniser for bringing asynchronous levels into the local clock domain.
module synch_2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pause_arbiter.sv
// Merges the menu-open flag and core pause requests into one frame-aligned core pause,
// with per-requester acknowledge and a latched cause bitmap.
module pause_arbiter
  import pause_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter bit          SYNC_VBLANK      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = PAUSE_TIMEOUT_DEF,
  parameter int unsigned MIN_PAUSE_CYCLES = PAUSE_MIN_HOLD_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               os_inmenu,
  input  logic [NUM_REQ-1:0] pause_req,
  input  logic               vblank,
  output logic               pause_core,
  output logic [NUM_REQ-1:0] pause_ack,
  output logic [NUM_REQ:0]   pause_src,
  output logic [1:0]         pause_state
);

  localparam int unsigned TW = pause_cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned HW = pause_cnt_w(MIN_PAUSE_CYCLES);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HoldMax  = HW'(MIN_PAUSE_CYCLES - 1);

  pause_state_t       r_state, w_state_d;
  logic [TW-1:0]      r_timer, w_timer_d;
  logic [HW-1:0]      r_hold, w_hold_d;
  logic               r_vblank_d;
  logic [NUM_REQ-1:0] r_ack, w_ack_d;
  logic [NUM_REQ:0]   r_src, w_src_d;

  logic               w_inmenu_s;
  logic [NUM_REQ:0]   w_active;
  logic               w_any;
  logic               w_edge_ok;
  logic               w_hold_sat;
  logic               w_paused;

  synch_2 #(
    .WIDTH (1)
  ) u_inmenu_sync (
    .i_clk   (clk_sys),
    .i_reset (reset),
    .i_d     (os_inmenu),
    .o_q     (w_inmenu_s)
  );

  assign w_active   = {pause_req, w_inmenu_s};
  assign w_any      = |w_active;
  assign w_edge_ok  = (vblank & ~r_vblank_d) | (r_timer == TimerMax);
  assign w_hold_sat = (r_hold == HoldMax);
  assign w_paused   = (r_state == PS_PAUSED) || (r_state == PS_PEND_RESUME);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= PS_RUN;
      r_timer    <= '0;
      r_hold     <= '0;
      r_vblank_d <= 1'b0;
      r_ack      <= '0;
      r_src      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_hold     <= w_hold_d;
      r_vblank_d <= vblank;
      r_ack      <= w_ack_d;
      r_src      <= w_src_d;
    end
  end

  // Cancel / re-request are checked before edge_ok so they win a same-cycle tie.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      PS_RUN: begin
        if (w_any) w_state_d = SYNC_VBLANK ? PS_PEND_PAUSE : PS_PAUSED;
      end
      PS_PEND_PAUSE: begin
        if (!w_any)         w_state_d = PS_RUN;
        else if (w_edge_ok) w_state_d = PS_PAUSED;
      end
      PS_PAUSED: begin
        if (!w_any && w_hold_sat) w_state_d = SYNC_VBLANK ? PS_PEND_RESUME : PS_RUN;
      end
      PS_PEND_RESUME: begin
        if (w_any)          w_state_d = PS_PAUSED;
        else if (w_edge_ok) w_state_d = PS_RUN;
      end
      default: w_state_d = PS_RUN;
    endcase
  end

  always_comb begin
    w_timer_d = '0;
    if ((w_state_d == r_state) &&
        ((r_state == PS_PEND_PAUSE) || (r_state == PS_PEND_RESUME))) begin
      w_timer_d = (r_timer == TimerMax) ? r_timer : r_timer + TW'(1);
    end

    w_hold_d = r_hold;
    if (w_state_d == PS_RUN) begin
      w_hold_d = '0;
    end else if ((r_state == PS_PAUSED) && !w_hold_sat) begin
      w_hold_d = r_hold + HW'(1);
    end

    w_ack_d = w_paused ? pause_req : '0;

    // Causes accumulate for the whole pause, including any PEND_RESUME bounces.
    w_src_d = '0;
    if (w_paused) begin
      w_src_d = (w_state_d == PS_RUN) ? '0 : (r_src | w_active);
    end else if (w_state_d == PS_PAUSED) begin
      w_src_d = w_active;
    end
  end

  always_comb begin
    pause_core  = (r_state == PS_PAUSED) || (r_state == PS_PEND_RESUME);
    pause_state = r_state;
    pause_ack   = r_ack;
    pause_src   = r_src;
  end

endmodule

// File: tb/tb_pause_arbiter.sv
// Directed self-checking bench for pause_arbiter (NUM_REQ=2, timeout 64, min hold 8).
module tb_pause_arbiter;

  logic       clk_sys;
  logic       reset;
  logic       os_inmenu;
  logic [1:0] pause_req;
  logic       vblank;
  logic       pause_core;
  logic [1:0] pause_ack;
  logic [2:0] pause_src;
  logic [1:0] pause_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  pause_arbiter #(
    .NUM_REQ          (2),
    .SYNC_VBLANK      (1'b1),
    .TIMEOUT_CYCLES   (64),
    .MIN_PAUSE_CYCLES (8)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .os_inmenu   (os_inmenu),
    .pause_req   (pause_req),
    .vblank      (vblank),
    .pause_core  (pause_core),
    .pause_ack   (pause_ack),
    .pause_src   (pause_src),
    .pause_state (pause_state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    reset     = 1'b1;
    os_inmenu = 1'b0;
    pause_req = 2'b00;
    vblank    = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    cyc   = 0;

    check("reset_state", 32'(pause_state), 32'd0);
    check("reset_core", 32'(pause_core), 32'd0);
    check("reset_ack", 32'(pause_ack), 32'd0);
    check("reset_src", 32'(pause_src), 32'd0);

    // Frame-aligned entry.
    run_to(5);
    pause_req = 2'b01;
    run_to(6);
    check("entry_pend", 32'(pause_state), 32'd1);
    run_to(40);
    check("entry_core_pre", 32'(pause_core), 32'd0);
    vblank = 1'b1;
    run_to(41);
    check("entry_core", 32'(pause_core), 32'd1);
    check("entry_state", 32'(pause_state), 32'd2);
    check("entry_src", 32'(pause_src), 32'b010);
    check("entry_ack_early", 32'(pause_ack), 32'd0);
    run_to(42);
    check("entry_ack", 32'(pause_ack), 32'b01);
    run_to(44);
    vblank = 1'b0;

    // Resume alignment: hold saturated by cycle 48.
    run_to(50);
    pause_req = 2'b00;
    run_to(51);
    check("resume_pend", 32'(pause_state), 32'd3);
    check("resume_core_hold", 32'(pause_core), 32'd1);
    check("resume_ack_drop", 32'(pause_ack), 32'd0);
    run_to(60);
    check("resume_core_wait", 32'(pause_core), 32'd1);
    vblank = 1'b1;
    run_to(61);
    check("resume_core", 32'(pause_core), 32'd0);
    check("resume_state", 32'(pause_state), 32'd0);
    check("resume_src", 32'(pause_src), 32'd0);
    check("resume_ack", 32'(pause_ack), 32'd0);
    run_to(62);
    vblank = 1'b0;

    // Cancel: request for 10 cycles with no vblank edge.
    run_to(65);
    pause_req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cancel_core", 32'(pause_core), 32'd0);
    end
    pause_req = 2'b00;
    run_to(70);
    check("cancel_pend", 32'(pause_state), 32'd1);
    run_to(76);
    check("cancel_run", 32'(pause_state), 32'd0);
    check("cancel_core_end", 32'(pause_core), 32'd0);

    // Menu plus timeout: vblank stays low.
    run_to(80);
    os_inmenu = 1'b1;
    run_to(82);
    check("menu_sync_delay", 32'(pause_state), 32'd0);
    run_to(83);
    check("menu_pend", 32'(pause_state), 32'd1);
    run_to(146);
    check("menu_core_pre", 32'(pause_core), 32'd0);
    run_to(147);
    check("menu_timeout_core", 32'(pause_core), 32'd1);
    check("menu_src", 32'(pause_src), 32'b001);

    // Min hold: drop the menu early, resume must wait for hold to saturate.
    run_to(148);
    os_inmenu = 1'b0;
    run_to(154);
    check("hold_paused", 32'(pause_state), 32'd2);
    run_to(155);
    check("hold_pend_resume", 32'(pause_state), 32'd3);
    run_to(157);
    pause_req = 2'b01;
    run_to(158);
    check("rereq_paused", 32'(pause_state), 32'd2);
    run_to(159);
    check("rereq_ack", 32'(pause_ack), 32'b01);
    check("rereq_src", 32'(pause_src), 32'b011);

    // Reset mid-pause.
    run_to(160);
    pause_req = 2'b11;
    run_to(162);
    check("rst_pre_ack", 32'(pause_ack), 32'b11);
    check("rst_pre_core", 32'(pause_core), 32'd1);
    reset = 1'b1;
    run_to(163);
    reset = 1'b0;
    check("rst_core", 32'(pause_core), 32'd0);
    check("rst_ack", 32'(pause_ack), 32'd0);
    check("rst_state", 32'(pause_state), 32'd0);
    run_to(164);
    check("rst_repend", 32'(pause_state), 32'd1);

    // A vblank edge coinciding with RUN->PEND_PAUSE is ignored.
    run_to(165);
    pause_req = 2'b00;
    run_to(166);
    check("ign_run", 32'(pause_state), 32'd0);
    run_to(170);
    pause_req = 2'b10;
    vblank    = 1'b1;
    run_to(171);
    check("ign_pend", 32'(pause_state), 32'd1);
    run_to(175);
    check("ign_still_pend", 32'(pause_state), 32'd1);
    check("ign_core", 32'(pause_core), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pause_arbiter.md
Name: pause_arbiter

Overview:
- Merges the Pocket menu-open flag with up to NUM_REQ core-side pause requests into one frame-aligned pause for the core.
- Enters and leaves pause only on a vblank rising edge, so the image never tears. A timeout fallback covers the case where vblank stops.
- Returns a per-requester acknowledge, and a latched cause bitmap for debug and the bridge status register.
- Sits in the Pocket interface layer, between the APF bridge/controller logic and the core's pause input.

Parameters:
- NUM_REQ, 4: number of core-side pause requesters (min 1).
- SYNC_VBLANK, 1: 1 = align pause entry and exit to vblank rising edge; 0 = switch immediately.
- TIMEOUT_CYCLES, 1000000: maximum clk_sys cycles to wait for a vblank edge before forcing the transition.
- MIN_PAUSE_CYCLES, 16: minimum cycles spent in PAUSED before a resume may begin.

Ports:
- clk_sys, in, 1: system clock; all logic in this domain.
- reset, in, 1: synchronous, active-high reset.
- os_inmenu, in, 1: menu open; asynchronous; synchronised internally via synch_2.
- pause_req, in, NUM_REQ: level pause requests, already synchronous to clk_sys.
- vblank, in, 1: core vertical blank, synchronous to clk_sys.
- pause_core, out, 1: pause to core, high in PAUSED and PEND_RESUME.
- pause_ack, out, NUM_REQ: per-requester grant, registered.
- pause_src, out, NUM_REQ+1: latched causes; bit 0 = menu, bit i+1 = pause_req[i].
- pause_state, out, 2: current FSM state (debug).

Behaviour:
- Signal definitions:
  - active = {pause_req, inmenu_s}.
  - any = |active.
  - vb_rise = vblank & ~vblank_d, where vblank_d is vblank registered one cycle.
  - edge_ok = vb_rise | (timer == TIMEOUT_CYCLES-1).
- Reset: state=RUN, timer=0, hold=0, vblank_d=0, pause_core=0, pause_ack=0, pause_src=0, sync flops=0. Reset asserted mid-pause drops pause_core on the next edge.
- State RUN (pause_core=0):
  - any=1 -> PEND_PAUSE, timer cleared.
  - If SYNC_VBLANK=0, any=1 -> PAUSED directly.
- State PEND_PAUSE (pause_core=0, timer increments):
  - any=0 -> RUN (cancel; no pause pulse).
  - else edge_ok -> PAUSED.
  - Cancel has priority over edge_ok when both occur in the same cycle.
- State PAUSED (pause_core=1):
  - hold increments, saturating at MIN_PAUSE_CYCLES-1.
  - any=0 and hold saturated -> PEND_RESUME, timer cleared.
  - If SYNC_VBLANK=0, the same condition -> RUN.
- State PEND_RESUME (pause_core=1, timer increments):
  - any=1 -> PAUSED; hold is not cleared.
  - else edge_ok -> RUN.
  - Re-request has priority over edge_ok in the same cycle.
- pause_core is decoded directly from the state register.
- Latency:
  - pause_req sampled at edge k moves state at edge k; pause_core is high in the following cycle.
  - os_inmenu adds 2 cycles of synchroniser delay.
- hold clears on entry to RUN.
- timer width is $clog2(TIMEOUT_CYCLES). timer clears on every state change and saturates; it never wraps.
- pause_ack[i] register:
  - Set at edge when state is PAUSED/PEND_RESUME and pause_req[i]=1.
  - Cleared at edge when pause_req[i]=0 or state=RUN/PEND_PAUSE.
  - A requester that raises its request while already paused gets its ack 1 cycle later, with no frame wait.
- pause_src:
  - Loaded with active on entry to PAUSED.
  - ORed with active every cycle in PAUSED/PEND_RESUME.
  - Cleared on entry to RUN.
- A vblank edge arriving in the same cycle as the RUN->PEND_PAUSE transition is not used; the next edge is waited for.

Decomposition:
- pause_pkg holds:
  - typedef enum logic [1:0] pause_state_t {PS_RUN=0, PS_PEND_PAUSE=1, PS_PAUSED=2, PS_PEND_RESUME=3};
  - default constants PAUSE_TIMEOUT_DEF and PAUSE_MIN_HOLD_DEF.
- No new sub-module. Reuse the existing synch_2 two-flop synchroniser for os_inmenu.
- FSM, timer and ack logic stay in one module.

Test Plan (bench params: NUM_REQ=2, TIMEOUT_CYCLES=64, MIN_PAUSE_CYCLES=8, SYNC_VBLANK=1; vblank period 40 cycles):
- Frame-aligned entry: pause_req=2'b01 at cycle 5, vb_rise at cycle 40 -> pause_core=0 through cycle 40, =1 from cycle 41; pause_ack=2'b01 from cycle 42; pause_src=3'b010.
- Cancel: pause_req[1] high at cycle 45 for 10 cycles, no vb_rise in window -> pause_core never asserts; state returns to PS_RUN at cycle 56.
- Menu plus timeout: vblank held 0, os_inmenu rises at cycle 0 -> PEND_PAUSE from cycle 3; pause_core=1 after 64 timer cycles (cycle 67); pause_src=3'b001.
- Min hold and re-request: pause, drop all requests 2 cycles into PAUSED -> stay PAUSED until hold reaches 7. Re-raise pause_req[0] during PEND_RESUME -> back to PAUSED with no pause_core glitch.
- Resume alignment: requests drop in PAUSED (hold saturated) -> pause_core stays 1 until the next vb_rise, =0 the cycle after; pause_src and pause_ack = 0.
- Reset mid-pause: assert reset 1 cycle while PAUSED with pause_req=2'b11 -> next cycle pause_core=0, pause_ack=0, pause_state=0. Requests still high -> PEND_PAUSE the following cycle.
